// File: rtl/audio_transport_ctrl_if.sv
// Control/status bundle between the recorder UI logic and the transport controller.
// The controller uses the slave view; the UI side or a bench drives through master.
interface audio_transport_ctrl_if #(
   parameter int ADDR_W = 20
);
   logic              key_start;
   logic              key_pause;
   logic              key_stop;
   logic              key_up;
   logic              key_down;
   logic              sw_record;
   logic              sw_interp;
   logic              sample_tick;
   logic [2:0]        state;
   logic [2:0]        ratio;
   logic              isNormalSpeed;
   logic              interp;
   logic              pause;
   logic              isRecord;
   logic              is_fast;
   logic [3:0]        speed_lvl;
   logic [ADDR_W-1:0] addr;
   logic              addr_we;
   logic [ADDR_W:0]   rec_len;
   logic              done;

   modport slave (
      input  key_start, key_pause, key_stop, key_up, key_down,
      input  sw_record, sw_interp, sample_tick,
      output state, ratio, isNormalSpeed, interp, pause, isRecord,
      output is_fast, speed_lvl, addr, addr_we, rec_len, done
   );

   modport master (
      output key_start, key_pause, key_stop, key_up, key_down,
      output sw_record, sw_interp, sample_tick,
      input  state, ratio, isNormalSpeed, interp, pause, isRecord,
      input  is_fast, speed_lvl, addr, addr_we, rec_len, done
   );
endinterface

// File: rtl/audio_transport_ctrl.sv
// Record/play transport: key-driven FSM, signed speed level and the
// sample-memory address counter for recording and variable-speed playback.
module audio_transport_ctrl #(
   parameter int ADDR_W = 20
) (
   input  logic                    clk50,
   input  logic                    rst_n,
   audio_transport_ctrl_if.slave   bus
);
   localparam int AW1 = ADDR_W + 1;
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_REC        = 3'd1;
   localparam logic [2:0] S_REC_PAUSE  = 3'd2;
   localparam logic [2:0] S_PLAY       = 3'd3;
   localparam logic [2:0] S_PLAY_PAUSE = 3'd4;
   localparam logic [ADDR_W-1:0] MAX_ADDR = '1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   rec_len_q, rec_len_d;
   logic signed [3:0] lvl_q, lvl_d;
   logic [2:0]        sub_q, sub_d;
   logic              done_q, done_d;
   logic              interp_q;

   logic [3:0]        mag;
   logic [ADDR_W:0]   f_w;
   logic [ADDR_W:0]   nxt;
   logic              step_en;
   logic              lvl_pos;
   logic              lvl_neg;
   logic              is_rec;

   assign lvl_neg = lvl_q[3];
   assign lvl_pos = !lvl_q[3] && (lvl_q != 4'sd0);
   assign mag     = lvl_neg ? 4'(-lvl_q) : 4'(lvl_q);
   assign f_w     = AW1'(mag) + 1'b1;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         rec_len_q <= '0;
         lvl_q     <= 4'sd0;
         sub_q     <= 3'd0;
         done_q    <= 1'b0;
         interp_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rec_len_q <= rec_len_d;
         lvl_q     <= lvl_d;
         sub_q     <= sub_d;
         done_q    <= done_d;
         interp_q  <= bus.sw_interp;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rec_len_d = rec_len_q;
      lvl_d     = lvl_q;
      sub_d     = sub_q;
      done_d    = 1'b0;
      nxt       = {1'b0, addr_q} + 1'b1;
      step_en   = 1'b0;

      if (bus.key_stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         addr_d  = '0;
         sub_d   = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.key_start) begin
                  if (bus.sw_record) begin
                     state_d   = S_REC;
                     addr_d    = '0;
                     rec_len_d = '0;
                  end else if (rec_len_q != '0) begin
                     state_d = S_PLAY;
                     addr_d  = '0;
                     sub_d   = 3'd0;
                  end
               end
            end
            S_REC: begin
               // The tick's write happens this cycle, so it is committed even if paused now.
               if (bus.sample_tick) begin
                  rec_len_d = {1'b0, addr_q} + 1'b1;
                  addr_d    = addr_q + 1'b1;
                  if (addr_q == MAX_ADDR) begin
                     state_d = S_IDLE;
                     addr_d  = '0;
                     done_d  = 1'b1;
                  end
               end
               if (bus.key_pause && !done_d) state_d = S_REC_PAUSE;
            end
            S_REC_PAUSE: begin
               if (bus.key_pause || bus.key_start) state_d = S_REC;
            end
            S_PLAY: begin
               if (bus.sample_tick) begin
                  step_en = 1'b1;
                  if (lvl_neg) begin
                     if (sub_q == mag[2:0]) begin
                        sub_d = 3'd0;
                     end else begin
                        sub_d   = sub_q + 3'd1;
                        step_en = 1'b0;
                     end
                  end
                  nxt = {1'b0, addr_q} + (lvl_pos ? f_w : AW1'(1));
                  if (step_en) begin
                     if (nxt >= rec_len_q) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        sub_d   = 3'd0;
                        done_d  = 1'b1;
                     end else begin
                        addr_d = nxt[ADDR_W-1:0];
                     end
                  end
               end
               if (bus.key_pause && !done_d) state_d = S_PLAY_PAUSE;
            end
            S_PLAY_PAUSE: begin
               if (bus.key_pause || bus.key_start) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Speed changes apply from the next tick; a tick in this cycle used the old level.
      if ((state_q == S_IDLE || state_q == S_PLAY || state_q == S_PLAY_PAUSE) &&
          (bus.key_up != bus.key_down)) begin
         if (bus.key_up && lvl_q != 4'sd7) begin
            lvl_d = lvl_q + 4'sd1;
            sub_d = 3'd0;
         end else if (bus.key_down && lvl_q != -4'sd7) begin
            lvl_d = lvl_q - 4'sd1;
            sub_d = 3'd0;
         end
      end
   end

   always_comb begin
      is_rec            = (state_q == S_REC) || (state_q == S_REC_PAUSE);
      bus.state         = state_q;
      bus.isRecord      = is_rec;
      bus.pause         = (state_q == S_IDLE) || (state_q == S_REC_PAUSE) ||
                          (state_q == S_PLAY_PAUSE);
      bus.ratio         = (lvl_neg && !is_rec) ? mag[2:0] : 3'd0;
      bus.isNormalSpeed = (lvl_q == 4'sd0) || is_rec;
      bus.is_fast       = lvl_pos && !is_rec;
      bus.speed_lvl     = lvl_q;
      bus.addr          = addr_q;
      bus.addr_we       = (state_q == S_REC) && bus.sample_tick;
      bus.rec_len       = rec_len_q;
      bus.done          = done_q;
      bus.interp        = interp_q;
   end
endmodule
